// File: rtl/hazard_pkg.sv
// Shared types for the hazard and forwarding controller.
// Optional perf counters in the top are enabled by HAZARD_PERF_EN.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int FWD_SEL_W  = 2;

    typedef enum logic [FWD_SEL_W-1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_info_t;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_select.sv
// Picks the forwarding source for one ALU operand.
// The producer nearest to EX wins, and x0 never forwards.
module fwd_select
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_rw,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_rw,
    output fwd_sel_t              sel
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = ex_rw && (ex_rd != '0) && (ex_rd == src);
    assign mem_hit = mem_rw && (mem_rd != '0) && (mem_rd == src);

    always_comb begin
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_EXMEM;
        end else if (mem_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Load-use stall, branch flush, memory freeze and operand forwarding control.
// Define HAZARD_PERF_EN to add the stall_cycles / flush_count counters.
module hazard_fwd_ctrl
    import hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  pipe_freeze,
    output logic [FWD_SEL_W-1:0]  fwd_a_sel,
    output logic [FWD_SEL_W-1:0]  fwd_b_sel
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
`endif
);

    stage_info_t ex_q;
    stage_info_t mem_q;
    stage_info_t wb_q;
    stage_info_t id_info;
    fwd_sel_t    fwd_a_q;
    fwd_sel_t    fwd_b_q;
    fwd_sel_t    sel_a;
    fwd_sel_t    sel_b;

    logic load_use;
    logic freeze;
    logic branch;
    logic lu_stall;
    logic unused_ok;

    assign load_use = id_valid && ex_q.mem_read && ex_q.reg_write
                   && (ex_q.rd != '0)
                   && ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

    assign freeze   = mem_busy;
    assign branch   = ex_branch_taken && !mem_busy;
    assign lu_stall = load_use && !ex_branch_taken && !mem_busy;

    assign pc_stall     = freeze || lu_stall;
    assign if_id_stall  = freeze || lu_stall;
    assign pipe_freeze  = freeze;
    assign if_id_flush  = branch;
    assign id_ex_bubble = branch || lu_stall;

    // Invalid slots enter EX as a clean NOP so they can never match.
    assign id_info.rd        = id_valid ? id_rd : '0;
    assign id_info.reg_write = id_valid && id_reg_write;
    assign id_info.mem_read  = id_valid && id_mem_read;

    fwd_select u_sel_a (
        .src    (id_rs1),
        .ex_rd  (ex_q.rd),
        .ex_rw  (ex_q.reg_write),
        .mem_rd (mem_q.rd),
        .mem_rw (mem_q.reg_write),
        .sel    (sel_a)
    );

    fwd_select u_sel_b (
        .src    (id_rs2),
        .ex_rd  (ex_q.rd),
        .ex_rw  (ex_q.reg_write),
        .mem_rd (mem_q.rd),
        .mem_rw (mem_q.reg_write),
        .sel    (sel_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else if (!freeze) begin
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (branch || lu_stall) begin
                ex_q    <= '0;
                fwd_a_q <= FWD_RF;
                fwd_b_q <= FWD_RF;
            end else begin
                ex_q    <= id_info;
                fwd_a_q <= sel_a;
                fwd_b_q <= sel_b;
            end
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

    // WB state is kept for debug visibility; nothing downstream consumes it here.
    assign unused_ok = ^{wb_q, mem_q.mem_read};

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (freeze || lu_stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (branch) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed scenarios plus
// randomized traffic against an in-bench pipeline model.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       ex_branch_taken;
    logic       mem_busy;
    logic       pc_stall;
    logic       if_id_stall;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       pipe_freeze;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: index 0 = EX, 1 = MEM, 2 = WB
    int          m_rd [3];
    bit          m_rw [3];
    bit          m_ld;
    int          m_a;
    int          m_b;
    bit [31:0]   m_stall;
    bit [31:0]   m_flush;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .pipe_freeze     (pipe_freeze),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    function automatic logic [4:0] ctrl_obs();
        return {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pipe_freeze};
    endfunction

    function automatic bit m_load_use();
        if (!id_valid || !m_ld || !m_rw[0] || m_rd[0] == 0) return 1'b0;
        return (m_rd[0] == int'(id_rs1)) || (m_rd[0] == int'(id_rs2));
    endfunction

    // Newest in-flight writer of rs: EX -> 1, MEM -> 2, else register file.
    function automatic int m_src(int rs);
        if (rs == 0) return 0;
        for (int i = 0; i < 2; i++)
            if (m_rw[i] && m_rd[i] == rs) return i + 1;
        return 0;
    endfunction

    function automatic logic [4:0] exp_ctrl();
        bit fz, br, lu;
        fz = mem_busy;
        br = !fz && ex_branch_taken;
        lu = !fz && !br && m_load_use();
        return {fz || lu, fz || lu, br, br || lu, fz};
    endfunction

    task automatic model_update();
        bit fz, br, lu;
        int na, nb;
        fz = mem_busy;
        br = !fz && ex_branch_taken;
        lu = !fz && !br && m_load_use();
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_rd[i] = 0;
                m_rw[i] = 0;
            end
            m_ld = 0; m_a = 0; m_b = 0;
            m_stall = 0; m_flush = 0;
        end else begin
            if (fz || lu) m_stall = m_stall + 1;
            if (br) m_flush = m_flush + 1;
            if (!fz) begin
                na = m_src(int'(id_rs1));
                nb = m_src(int'(id_rs2));
                for (int i = 2; i > 0; i--) begin
                    m_rd[i] = m_rd[i-1];
                    m_rw[i] = m_rw[i-1];
                end
                if (br || lu) begin
                    m_rd[0] = 0; m_rw[0] = 0; m_ld = 0;
                    m_a = 0; m_b = 0;
                end else begin
                    m_rd[0] = id_valid ? int'(id_rd) : 0;
                    m_rw[0] = id_valid && id_reg_write;
                    m_ld    = id_valid && id_mem_read;
                    m_a = na; m_b = nb;
                end
            end
        end
    endtask

    task automatic set_id(bit v, int rs1, int rs2, int rd, bit rw, bit ld);
        id_valid     = v;
        id_rs1       = 5'(rs1);
        id_rs2       = 5'(rs2);
        id_rd        = 5'(rd);
        id_reg_write = rw;
        id_mem_read  = ld;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ex_branch_taken = 1'b0;
        mem_busy = 1'b0;
        set_id(0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({ctrl_obs(), fwd_a_sel, fwd_b_sel} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b",
                     {ctrl_obs(), fwd_a_sel, fwd_b_sel}, 9'b0);
        end
        mem_busy = 1'b1;
        #1;
        n_chk++;
        if (ctrl_obs() !== 5'b11001) begin
            n_fail++;
            $display("FAIL reset_busy_ctrl: got %b expected %b", ctrl_obs(), 5'b11001);
        end
        mem_busy = 1'b0;
        #1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_id(1, 1, 2, 5, 1, 0);
        tick();
        set_id(1, 5, 1, 6, 1, 0);
        tick();
        n_chk++;
        if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_exmem: got a=%0d b=%0d expected a=1 b=0", fwd_a_sel, fwd_b_sel);
        end
        do_reset();
        set_id(1, 1, 2, 5, 1, 0);
        tick();
        set_id(1, 2, 3, 9, 1, 0);
        tick();
        set_id(1, 5, 1, 6, 1, 0);
        tick();
        n_chk++;
        if (fwd_a_sel !== 2'd2 || fwd_b_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_memwb: got a=%0d b=%0d expected a=2 b=0", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 1, 0, 7, 1, 1);
        tick();
        set_id(1, 7, 7, 8, 1, 0);
        n_chk++;
        if (ctrl_obs() !== 5'b11010) begin
            n_fail++;
            $display("FAIL lu_stall: got %b expected %b", ctrl_obs(), 5'b11010);
        end
        tick();
        n_chk++;
        if (ctrl_obs() !== 5'b00000 || fwd_a_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL lu_one_cycle: got ctrl=%b a=%0d expected ctrl=00000 a=0",
                     ctrl_obs(), fwd_a_sel);
        end
        tick();
        n_chk++;
        if (fwd_a_sel !== 2'd2 || fwd_b_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL lu_fwd: got a=%0d b=%0d expected a=2 b=2", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_branch();
        do_reset();
        set_id(1, 1, 0, 7, 1, 1);
        tick();
        ex_branch_taken = 1'b1;
        set_id(1, 7, 7, 8, 1, 0);
        n_chk++;
        if (ctrl_obs() !== 5'b00110) begin
            n_fail++;
            $display("FAIL br_flush: got %b expected %b", ctrl_obs(), 5'b00110);
        end
        tick();
        ex_branch_taken = 1'b0;
        #1;
        n_chk++;
        if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL br_fwd_clear: got a=%0d b=%0d expected 0 0", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_freeze();
        int bad = 0;
        do_reset();
        set_id(1, 1, 2, 5, 1, 0);
        tick();
        set_id(1, 5, 5, 6, 1, 0);
        tick();
        set_id(1, 6, 5, 7, 1, 0);
        mem_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_chk++;
            if (ctrl_obs() !== 5'b11001) begin
                n_fail++;
                $display("FAIL frz_ctrl_%0d: got %b expected %b", c, ctrl_obs(), 5'b11001);
            end
            tick();
            n_chk++;
            if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd1) begin
                n_fail++;
                $display("FAIL frz_hold_%0d: got a=%0d b=%0d expected 1 1",
                         c, fwd_a_sel, fwd_b_sel);
            end
        end
        mem_busy = 1'b0;
        #1;
        n_chk++;
        if (ctrl_obs() !== 5'b00000) begin
            n_fail++;
            $display("FAIL frz_release: got %b expected %b", ctrl_obs(), 5'b00000);
        end
        tick();
        n_chk++;
        if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL frz_resume: got a=%0d b=%0d expected 1 2", fwd_a_sel, fwd_b_sel);
        end
        if (bad != 0) n_fail++;
    endtask

    task automatic test_x0();
        do_reset();
        set_id(1, 1, 2, 0, 1, 0);
        tick();
        set_id(1, 0, 0, 3, 1, 0);
        tick();
        n_chk++;
        if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL x0_fwd: got a=%0d b=%0d expected 0 0", fwd_a_sel, fwd_b_sel);
        end
        set_id(1, 1, 0, 0, 1, 1);
        tick();
        set_id(1, 0, 0, 4, 1, 0);
        n_chk++;
        if (ctrl_obs() !== 5'b00000) begin
            n_fail++;
            $display("FAIL x0_lw_nostall: got %b expected %b", ctrl_obs(), 5'b00000);
        end
        tick();
        n_chk++;
        if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL x0_lw_fwd: got a=%0d b=%0d expected 0 0", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1, 1, 0, 7, 1, 1);
        tick();
        set_id(1, 7, 7, 8, 1, 0);
        n_chk++;
        if (ctrl_obs() !== 5'b11010) begin
            n_fail++;
            $display("FAIL rst_pre_stall: got %b expected %b", ctrl_obs(), 5'b11010);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_chk++;
        if ({ctrl_obs(), fwd_a_sel, fwd_b_sel} !== 9'b0) begin
            n_fail++;
            $display("FAIL rst_mid_stall: got %b expected %b",
                     {ctrl_obs(), fwd_a_sel, fwd_b_sel}, 9'b0);
        end
`ifdef HAZARD_PERF_EN
        n_chk++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset: got %0d/%0d expected 0/0", stall_cycles, flush_count);
        end
        set_id(1, 1, 0, 7, 1, 1);
        tick();
        set_id(1, 7, 7, 8, 1, 0);
        tick();
        n_chk++;
        if (stall_cycles !== 32'd1 || flush_count !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_one_stall: got %0d/%0d expected 1/0", stall_cycles, flush_count);
        end
`endif
    endtask

    task automatic test_random();
        logic [4:0] ec;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset           = ($urandom_range(0, 49) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            mem_busy        = ($urandom_range(0, 7) == 0);
            set_id($urandom_range(0, 5) != 0,
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            ec = exp_ctrl();
            n_chk++;
            if (ctrl_obs() !== ec) begin
                n_fail++;
                $display("FAIL rnd_ctrl c%0d: got %b expected %b", c, ctrl_obs(), ec);
            end
            tick();
            n_chk++;
            if (int'(fwd_a_sel) != m_a || int'(fwd_b_sel) != m_b || $isunknown({fwd_a_sel, fwd_b_sel})) begin
                n_fail++;
                $display("FAIL rnd_fwd c%0d: got a=%0d b=%0d expected a=%0d b=%0d",
                         c, fwd_a_sel, fwd_b_sel, m_a, m_b);
            end
`ifdef HAZARD_PERF_EN
            n_chk++;
            if (stall_cycles !== m_stall || flush_count !== m_flush) begin
                n_fail++;
                $display("FAIL rnd_perf c%0d: got %0d/%0d expected %0d/%0d",
                         c, stall_cycles, flush_count, m_stall, m_flush);
            end
`endif
        end
        reset = 1'b0;
        ex_branch_taken = 1'b0;
        mem_busy = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ex_branch_taken = 1'b0;
        mem_busy = 1'b0;
        set_id(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_load_use();
        test_branch();
        test_freeze();
        test_x0();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
